// File: rtl/clk_enable_gen_pkg.sv
// rtl/clk_enable_gen_pkg.sv - shared types and defaults for the clock-enable generator
package clk_enable_gen_pkg;

    // Lock-qualification / run sequencing states
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int unsigned LOCK_CYCLES_DEFAULT = 1024;

    // Width of a channel index; a single channel still needs a 1-bit select
    function automatic int ch_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_enable_nco_ch.sv
// rtl/clk_enable_nco_ch.sv - one phase-accumulator channel with staged increment update
module clk_enable_nco_ch #(
    parameter int              ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             wr_i,
    input  logic [ACC_W-1:0] wr_inc_i,
    output logic             pending_o,
    output logic             strobe_o,
    output logic             sq_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
    logic             pending_q, pending_d;
    logic             strobe_q, strobe_d;
    logic [ACC_W:0]   sum;
    logic             apply;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // Next-state: accumulate in run, swap increments only at a carry so the cadence never glitches
    always_comb begin
        acc_d      = acc_q;
        inc_d      = inc_q;
        pend_inc_d = pend_inc_q;
        pending_d  = pending_q;
        strobe_d   = 1'b0;
        if (run_i) begin
            acc_d    = sum[ACC_W-1:0];
            strobe_d = sum[ACC_W];
        end else begin
            acc_d    = '0;
        end
        apply = pending_q & (run_i ? sum[ACC_W] : 1'b1);
        if (apply) begin
            inc_d     = pend_inc_q;
            pending_d = 1'b0;
        end
        // wr_i is only asserted while pending_q is clear, so it never races with apply
        if (wr_i) begin
            pend_inc_d = wr_inc_i;
            pending_d  = 1'b1;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            inc_q      <= DEFAULT_INC;
            pend_inc_q <= '0;
            pending_q  <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            pend_inc_q <= pend_inc_d;
            pending_q  <= pending_d;
            strobe_q   <= strobe_d;
        end
    end

    assign pending_o = pending_q;
    assign strobe_o  = strobe_q;
    assign sq_o      = acc_q[ACC_W-1];

endmodule

// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - PLL-lock-qualified multi-channel NCO clock-enable generator
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int               N_CH        = 2,
    parameter int               ACC_W       = 32,
    parameter int               LOCK_CYCLES = LOCK_CYCLES_DEFAULT,
    parameter logic [ACC_W-1:0] DEFAULT_INC = '0,
    localparam int              CH_W        = ch_idx_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             ready,
    output logic [N_CH-1:0]  strobe,
    output logic [N_CH-1:0]  sq
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);
    // Entering RUN happens on the edge where the counter reaches LOCK_CYCLES-1
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_CYCLES - 2);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            ready_q;
    logic            run_en;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;

    // Lock qualification: count consecutive locked cycles, any unlock restarts from zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (pll_lock) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!pll_lock) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!pll_lock) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, settle counter and registered ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
        end
    end

    assign ready = ready_q;

    // Accumulators advance only while running and still locked; losing lock clears them on that edge
    assign run_en = (state_q == RUN) & pll_lock;

    // Out-of-range channel selects report ready so the write is silently dropped
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

        clk_enable_nco_ch #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .run_i     (run_en),
            .wr_i      (wr[i]),
            .wr_inc_i  (cfg_inc),
            .pending_o (pending[i]),
            .strobe_o  (strobe[i]),
            .sq_o      (sq[i])
        );
    end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter N_CH, default 2: number of independent clock-enable channels, range 1..8.
REQ-002 Parameter ACC_W, default 32: phase-accumulator width in bits, range 8..32.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive cycles pll_lock must stay high before the block runs, minimum 2.
REQ-004 Parameter DEFAULT_INC, default 0: increment loaded into every channel at reset, ACC_W bits.
REQ-005 clk  in  1  sole clock; all logic is on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 pll_lock  in  1  lock indication from the PLL; treated as synchronous to clk.
REQ-008 cfg_valid  in  1  increment write request.
REQ-009 cfg_ready  out  1  write may be accepted this cycle.
REQ-010 cfg_ch  in  max(1,$clog2(N_CH))  target channel; values >= N_CH are accepted and discarded.
REQ-011 cfg_inc  in  ACC_W  new phase increment.
REQ-012 ready  out  1  high while in RUN.
REQ-013 strobe  out  N_CH  one-cycle enable pulse per channel on accumulator wrap.
REQ-014 sq  out  N_CH  per-channel square wave, equal to accumulator MSB.

Function
REQ-015 FSM states: WAIT_LOCK, SETTLE, RUN.
REQ-016 WAIT_LOCK: settle counter held at 0; pll_lock=1 moves to SETTLE.
REQ-017 SETTLE: counter increments each cycle pll_lock=1; pll_lock=0 returns to WAIT_LOCK with counter cleared; counter reaching LOCK_CYCLES-1 with pll_lock=1 moves to RUN.
REQ-018 The settle counter is $clog2(LOCK_CYCLES) bits and never wraps.
REQ-019 RUN: pll_lock=0 returns to WAIT_LOCK; all accumulators, strobe and sq clear on that same edge.
REQ-020 ready is registered and equals (state==RUN).
REQ-021 In RUN, each edge: acc[i] <= (acc[i]+inc[i]) mod 2^ACC_W; strobe[i] <= carry-out of that addition.
REQ-022 Outside RUN, accumulators hold 0 and strobe is 0.
REQ-023 inc=0 produces no strobe; inc=2^ACC_W-1 produces a strobe on every cycle except the first accumulation after entering RUN.
REQ-024 Each channel holds a pending increment register and a pending flag.
REQ-025 cfg_ready = ~pending[cfg_ch], combinational; discarded channels report cfg_ready=1.
REQ-026 A write is accepted when cfg_valid & cfg_ready; it sets pending and captures cfg_inc.
REQ-027 Outside RUN, a pending increment is applied to inc on the next edge.
REQ-028 In RUN, a pending increment is applied on the edge that produces a carry for that channel, so the new increment is used from the following accumulation; pending clears on the same edge.
REQ-029 A write to a channel whose pending flag is clear, arriving on that channel's carry edge, is captured but applied at the next carry.
REQ-030 inc values survive lock loss; only accumulators clear.

Reset
REQ-031 rst asserted: state=WAIT_LOCK, counter=0, acc=0, inc=DEFAULT_INC, pending=0, strobe=0, sq=0, ready=0.
REQ-032 rst asserted mid-operation clears pending writes without applying them.
REQ-033 After rst deasserts, no output changes until the first clk edge.

Structure
REQ-034 The FSM state enum and the LOCK_CYCLES default belong in shared package clk_enable_gen_pkg.
REQ-035 One sub-module, clk_enable_nco_ch (accumulator, increment, pending register for a single channel), is instantiated N_CH times.

Verification
REQ-036 ACC_W=8, LOCK_CYCLES=16: pll_lock high from cycle 0 -> ready rises after exactly 16 edges.
REQ-037 pll_lock drops at settle count 10 for one cycle -> ready not high until 16 further high cycles.
REQ-038 inc=64 on ch0 -> first strobe 4 cycles after ready, then every 4 cycles; sq period 4 with 50% duty.
REQ-039 Running ch0 inc=64, write inc=128 mid-period -> cfg_ready low until next carry, then strobe every 2 cycles.
REQ-040 pll_lock drops in RUN -> next edge ready=0, strobe=0, sq=0; after relock+16 cycles the same strobe cadence resumes with inc retained.
REQ-041 rst pulse while pending write outstanding -> inc returns to DEFAULT_INC, cfg_ready=1, ready=0.
